// File: rtl/regfile_pkg.sv
// Shared widths and request structs for the architectural register file.
// Index 0 is the hardwired-zero register.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int CNT_W    = 32;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
   } rd_req_t;

   function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
      return (idx == '0);
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset, enable and zero-index squash ahead of
// the write-through bypass, falling back to stored contents.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W,
   parameter int NR = NUM_REGS
) (
   input  logic                  rst,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DW-1:0]         wdata,
   input  logic [NR-1:0][DW-1:0] regs,
   output logic [DW-1:0]         rdata
);

   always_comb begin
      rdata = '0;
      if (rst) begin
         rdata = '0;
      end else if (!re) begin
         rdata = '0;
      end else if (raddr == '0) begin
         rdata = '0;
      end else if (we && (waddr == raddr)) begin
         // value retiring this cycle is visible to decode before the edge
         rdata = wdata;
      end else begin
         rdata = regs[raddr];
      end
   end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: one write port from write-back, two
// bypassed combinational read ports, and a committed-write counter.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W_P   = DATA_W,
   parameter int ADDR_W_P   = ADDR_W,
   parameter int NUM_REGS_P = NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [ADDR_W_P-1:0] waddr_i,
   input  logic [DATA_W_P-1:0] wdata_i,
   input  logic                re1_i,
   input  logic [ADDR_W_P-1:0] raddr1_i,
   output logic [DATA_W_P-1:0] rdata1_o,
   input  logic                re2_i,
   input  logic [ADDR_W_P-1:0] raddr2_i,
   output logic [DATA_W_P-1:0] rdata2_o,
   output logic [CNT_W-1:0]    wr_count_o
);

   logic [NUM_REGS_P-1:0][DATA_W_P-1:0] regs;
   logic [CNT_W-1:0]                    wr_cnt;
   logic                                commit;

   assign commit = we_i && (waddr_i != '0);

   // index 0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs   <= '0;
         wr_cnt <= '0;
      end else if (commit) begin
         regs[waddr_i] <= wdata_i;
         wr_cnt        <= wr_cnt + 1'b1;
      end
   end

   assign wr_count_o = wr_cnt;

   regfile_rd_port #(
      .DW (DATA_W_P),
      .AW (ADDR_W_P),
      .NR (NUM_REGS_P)
   ) u_rd_port1 (
      .rst   (rst),
      .re    (re1_i),
      .raddr (raddr1_i),
      .we    (we_i),
      .waddr (waddr_i),
      .wdata (wdata_i),
      .regs  (regs),
      .rdata (rdata1_o)
   );

   regfile_rd_port #(
      .DW (DATA_W_P),
      .AW (ADDR_W_P),
      .NR (NUM_REGS_P)
   ) u_rd_port2 (
      .rst   (rst),
      .re    (re2_i),
      .raddr (raddr2_i),
      .we    (we_i),
      .waddr (waddr_i),
      .wdata (wdata_i),
      .regs  (regs),
      .rdata (rdata2_o)
   );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, reset corner sequences,
// randomized traffic against an array model, and counter wrap.
module tb_regfile;

   logic        clk;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic        re1_i;
   logic [4:0]  raddr1_i;
   logic [31:0] rdata1_o;
   logic        re2_i;
   logic [4:0]  raddr2_i;
   logic [31:0] rdata2_o;
   logic [31:0] wr_count_o;

   int checks   = 0;
   int failures = 0;

   regfile dut (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .re1_i      (re1_i),
      .raddr1_i   (raddr1_i),
      .rdata1_o   (rdata1_o),
      .re2_i      (re2_i),
      .raddr2_i   (raddr2_i),
      .rdata2_o   (rdata2_o),
      .wr_count_o (wr_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[8];

   logic [31:0] mregs[32];
   logic [31:0] mcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2);
      we_i = we; waddr_i = wa; wdata_i = wd;
      re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
   endtask

   function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
      if (!en || a == 5'd0) return 32'h0;
      if (we_i && waddr_i == a) return wdata_i;
      return mregs[a];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // hand-derived expectations starting from an all-zero file
      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        32'd0};
      vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
      vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 5'd5, 32'h0,        32'hDEADBEEF, 32'd1};
      vecs[3] = '{1'b1, 5'd7, 32'h00001234, 1'b1, 5'd7, 1'b1, 5'd7, 32'h00001234, 32'h00001234, 32'd1};
      vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd7, 32'h0,        32'h00001234, 32'd2};
      vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd5, 32'h0,        32'hDEADBEEF, 32'd2};
      vecs[6] = '{1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd5, 1'b1, 5'd7, 32'hCAFEF00D, 32'h00001234, 32'd2};
      vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd9, 32'hCAFEF00D, 32'h0,        32'd3};

      // reads are forced to zero while reset is high, even with a bypass hit
      rst = 1'b1;
      drive(1'b1, 5'd4, 32'h55AA55AA, 1'b1, 5'd4, 1'b1, 5'd4);
      #2;
      check("rst_rd1", rdata1_o, 32'h0);
      check("rst_rd2", rdata2_o, 32'h0);
      check("rst_cnt", wr_count_o, 32'h0);
      @(posedge clk);
      #1;
      check("rst_wr_ignored_cnt", wr_count_o, 32'h0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
               vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
         @(negedge clk);
         check($sformatf("vec%0d_rd1", i), rdata1_o, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), rdata2_o, vecs[i].exp2);
         check($sformatf("vec%0d_cnt", i), wr_count_o, vecs[i].exp_cnt);
      end

      // reset pulse between edges clears storage and counter without a clock
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
      #1;
      check("pre_pulse_rd1", rdata1_o, 32'hCAFEF00D);
      rst = 1'b1;
      #1;
      check("pulse_rd1", rdata1_o, 32'h0);
      check("pulse_rd2", rdata2_o, 32'h0);
      check("pulse_cnt", wr_count_o, 32'h0);
      rst = 1'b0;
      #1;
      check("post_pulse_r5", rdata1_o, 32'h0);
      check("post_pulse_r7", rdata2_o, 32'h0);

      // write presented while reset rises must be discarded
      @(posedge clk);
      #1;
      drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
      #1;
      check("midrst_r3", rdata1_o, 32'h0);
      check("midrst_cnt", wr_count_o, 32'h0);

      for (int r = 0; r < 32; r += 2) begin
         @(posedge clk);
         #1;
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b1, 5'(r + 1));
         @(negedge clk);
         check($sformatf("clr_r%0d", r), rdata1_o, 32'h0);
         check($sformatf("clr_r%0d", r + 1), rdata2_o, 32'h0);
      end

      // randomized traffic from the all-zero state
      foreach (mregs[k]) mregs[k] = 32'h0;
      mcnt = 32'h0;
      for (int c = 0; c < 400; c++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(0, 31));
         @(posedge clk);
         #1;
         drive(1'($urandom_range(0, 1)), wa, $urandom,
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         @(negedge clk);
         check("rnd_rd1", rdata1_o, model_read(re1_i, raddr1_i));
         check("rnd_rd2", rdata2_o, model_read(re2_i, raddr2_i));
         check("rnd_cnt", wr_count_o, mcnt);
         if (we_i && waddr_i != 5'd0) begin
            mregs[waddr_i] = wdata_i;
            mcnt = mcnt + 32'd1;
         end
      end

      // counter wrap from all-ones
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      force dut.wr_cnt = 32'hFFFFFFFF;
      #1;
      release dut.wr_cnt;
      #1;
      check("wrap_pre", wr_count_o, 32'hFFFFFFFF);
      drive(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
      #1;
      check("wrap_cnt", wr_count_o, 32'h0);
      check("wrap_r9", rdata1_o, 32'h0BADF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
